// File: rtl/wb_write_arbiter_if.sv
// Writeback arbiter bus: pipeline and long-latency streams in,
// registered register-file write port and hazard status out.
interface wb_write_arbiter_if #(
  parameter int DW = 32
);
  logic          MEM_WB_RegWrite;
  logic [4:0]    MEM_WB_WriteRegister;
  logic [DW-1:0] WB_WriteData;
  logic          LL_Valid;
  logic          LL_Ready;
  logic [4:0]    LL_WriteRegister;
  logic [DW-1:0] LL_WriteData;
  logic          RF_RegWrite;
  logic [4:0]    RF_WriteRegister;
  logic [DW-1:0] RF_WriteData;
  logic [31:0]   Pending;
  logic          Queue_Full;

  modport slave (
    input  MEM_WB_RegWrite,
    input  MEM_WB_WriteRegister,
    input  WB_WriteData,
    input  LL_Valid,
    output LL_Ready,
    input  LL_WriteRegister,
    input  LL_WriteData,
    output RF_RegWrite,
    output RF_WriteRegister,
    output RF_WriteData,
    output Pending,
    output Queue_Full
  );

  modport master (
    output MEM_WB_RegWrite,
    output MEM_WB_WriteRegister,
    output WB_WriteData,
    output LL_Valid,
    input  LL_Ready,
    output LL_WriteRegister,
    output LL_WriteData,
    input  RF_RegWrite,
    input  RF_WriteRegister,
    input  RF_WriteData,
    input  Pending,
    input  Queue_Full
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// Register-file write port arbiter: pipeline writes win, long-latency
// results queue in a FIFO and drain into free slots.
module wb_write_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2,
  parameter int DW    = 32
) (
  input  logic               Clk,
  input  logic               Rst,
  wb_write_arbiter_if.slave  bus
);

  logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [AW:0]                cnt_q, cnt_d;
  logic [DEPTH-1:0][4:0]      ent_reg_q, ent_reg_d;
  logic [DEPTH-1:0][DW-1:0]   ent_data_q, ent_data_d;
  logic [DEPTH-1:0]           ent_live_q, ent_live_d;
  logic                       rf_we_q, rf_we_d;
  logic [4:0]                 rf_reg_q, rf_reg_d;
  logic [DW-1:0]              rf_data_q, rf_data_d;

  logic pipe_wr;
  logic full;
  logic push;
  logic pop;
  logic [31:0] pending;

  always_comb begin
    pipe_wr = bus.MEM_WB_RegWrite &&
              (bus.MEM_WB_WriteRegister != 5'd0);
    full    = (cnt_q == (AW+1)'(DEPTH));
    push    = bus.LL_Valid && !full &&
              (bus.LL_WriteRegister != 5'd0);
    pop     = !pipe_wr && (cnt_q != '0);
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ent_reg_d  = ent_reg_q;
    ent_data_d = ent_data_q;
    ent_live_d = ent_live_q;
    rf_we_d    = 1'b0;
    rf_reg_d   = rf_reg_q;
    rf_data_d  = rf_data_q;

    // A younger pipeline write supersedes queued results to the same reg
    for (int i = 0; i < DEPTH; i++) begin
      if (pipe_wr &&
          ent_reg_q[i] == bus.MEM_WB_WriteRegister)
        ent_live_d[i] = 1'b0;
    end

    if (pipe_wr) begin
      rf_we_d   = 1'b1;
      rf_reg_d  = bus.MEM_WB_WriteRegister;
      rf_data_d = bus.WB_WriteData;
    end else if (pop) begin
      ent_live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d = rd_ptr_q + AW'(1);
      if (ent_live_q[rd_ptr_q]) begin
        rf_we_d   = 1'b1;
        rf_reg_d  = ent_reg_q[rd_ptr_q];
        rf_data_d = ent_data_q[rd_ptr_q];
      end
    end

    if (push) begin
      ent_reg_d[wr_ptr_q]  = bus.LL_WriteRegister;
      ent_data_d[wr_ptr_q] = bus.LL_WriteData;
      ent_live_d[wr_ptr_q] = !(pipe_wr &&
        bus.LL_WriteRegister == bus.MEM_WB_WriteRegister);
      wr_ptr_d = wr_ptr_q + AW'(1);
    end

    cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_live_q[i])
        pending[ent_reg_q[i]] = 1'b1;
    end
    pending[0] = 1'b0;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ent_reg_q  <= '0;
      ent_data_q <= '0;
      ent_live_q <= '0;
      rf_we_q    <= 1'b0;
      rf_reg_q   <= '0;
      rf_data_q  <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ent_reg_q  <= ent_reg_d;
      ent_data_q <= ent_data_d;
      ent_live_q <= ent_live_d;
      rf_we_q    <= rf_we_d;
      rf_reg_q   <= rf_reg_d;
      rf_data_q  <= rf_data_d;
    end
  end

  assign bus.LL_Ready         = !full;
  assign bus.Queue_Full       = full;
  assign bus.Pending          = pending;
  assign bus.RF_RegWrite      = rf_we_q;
  assign bus.RF_WriteRegister = rf_reg_q;
  assign bus.RF_WriteData     = rf_data_q;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Directed bench for wb_write_arbiter: pipeline priority, FIFO drain,
// full backpressure, WAW kill, r0 filtering and async reset.
module tb_wb_write_arbiter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  wb_write_arbiter_if #(.DW(32)) bus ();

  wb_write_arbiter #(
    .DEPTH(4),
    .AW(2),
    .DW(32)
  ) u_dut (
    .Clk(clk),
    .Rst(rst_n),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pipe(input logic v, input logic [4:0] r,
                      input logic [31:0] d);
    bus.MEM_WB_RegWrite      = v;
    bus.MEM_WB_WriteRegister = r;
    bus.WB_WriteData         = d;
  endtask

  task automatic ll(input logic v, input logic [4:0] r,
                    input logic [31:0] d);
    bus.LL_Valid         = v;
    bus.LL_WriteRegister = r;
    bus.LL_WriteData     = d;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst_n = 1'b0;
    pipe(1'b0, 5'd0, 32'd0);
    ll(1'b0, 5'd0, 32'd0);
    #12;
    chk("rst_we", 64'(bus.RF_RegWrite), 64'd0);
    chk("rst_reg", 64'(bus.RF_WriteRegister), 64'd0);
    chk("rst_data", 64'(bus.RF_WriteData), 64'd0);
    chk("rst_pend", 64'(bus.Pending), 64'd0);
    chk("rst_full", 64'(bus.Queue_Full), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", 64'(bus.LL_Ready), 64'd1);

    // 1: plain pipeline write
    pipe(1'b1, 5'd5, 32'hDEADBEEF);
    tick();
    pipe(1'b0, 5'd0, 32'd0);
    chk("t1_we", 64'(bus.RF_RegWrite), 64'd1);
    chk("t1_reg", 64'(bus.RF_WriteRegister), 64'd5);
    chk("t1_data", 64'(bus.RF_WriteData), 64'hDEADBEEF);
    tick();
    chk("t1_we_off", 64'(bus.RF_RegWrite), 64'd0);
    chk("t1_hold", 64'(bus.RF_WriteRegister), 64'd5);

    // 2: single long-latency result
    ll(1'b1, 5'd8, 32'h11);
    tick();
    ll(1'b0, 5'd0, 32'd0);
    chk("t2_we0", 64'(bus.RF_RegWrite), 64'd0);
    chk("t2_pend", 64'(bus.Pending), 64'h100);
    tick();
    chk("t2_we", 64'(bus.RF_RegWrite), 64'd1);
    chk("t2_reg", 64'(bus.RF_WriteRegister), 64'd8);
    chk("t2_data", 64'(bus.RF_WriteData), 64'h11);
    chk("t2_pend0", 64'(bus.Pending), 64'd0);

    // 3: fill queue under sustained pipeline writes
    pipe(1'b1, 5'd10, 32'h50);
    for (int i = 1; i <= 4; i++) begin
      ll(1'b1, 5'(i), 32'h100 + 32'(i));
      tick();
      chk("t3_pipe", 64'(bus.RF_WriteRegister), 64'd10);
    end
    chk("t3_full", 64'(bus.Queue_Full), 64'd1);
    chk("t3_ready", 64'(bus.LL_Ready), 64'd0);
    chk("t3_pend", 64'(bus.Pending), 64'h1E);
    ll(1'b1, 5'd7, 32'h777);
    tick();
    chk("t3_held_full", 64'(bus.Queue_Full), 64'd1);
    chk("t3_held_pend", 64'(bus.Pending), 64'h1E);
    pipe(1'b0, 5'd0, 32'd0);
    ll(1'b0, 5'd0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk("t3_dr_we", 64'(bus.RF_RegWrite), 64'd1);
      chk("t3_dr_reg", 64'(bus.RF_WriteRegister), 64'(i));
      chk("t3_dr_data", 64'(bus.RF_WriteData),
          64'(32'h100 + 32'(i)));
    end
    chk("t3_empty_full", 64'(bus.Queue_Full), 64'd0);
    chk("t3_empty_pend", 64'(bus.Pending), 64'd0);
    tick();
    chk("t3_idle", 64'(bus.RF_RegWrite), 64'd0);

    // 4: WAW kill of a queued entry
    ll(1'b1, 5'd9, 32'hAA);
    tick();
    ll(1'b0, 5'd0, 32'd0);
    chk("t4_pend", 64'(bus.Pending), 64'h200);
    pipe(1'b1, 5'd9, 32'hBB);
    tick();
    pipe(1'b0, 5'd0, 32'd0);
    chk("t4_we", 64'(bus.RF_RegWrite), 64'd1);
    chk("t4_data", 64'(bus.RF_WriteData), 64'hBB);
    chk("t4_pend0", 64'(bus.Pending), 64'd0);
    tick();
    chk("t4_dead_pop", 64'(bus.RF_RegWrite), 64'd0);
    chk("t4_final", 64'(bus.RF_WriteData), 64'hBB);
    tick();
    chk("t4_idle", 64'(bus.RF_RegWrite), 64'd0);

    // 5: writes to r0 are dropped on both paths
    ll(1'b1, 5'd0, 32'h33);
    pipe(1'b1, 5'd0, 32'h44);
    tick();
    ll(1'b0, 5'd0, 32'd0);
    pipe(1'b0, 5'd0, 32'd0);
    chk("t5_we", 64'(bus.RF_RegWrite), 64'd0);
    chk("t5_pend", 64'(bus.Pending), 64'd0);
    tick();
    chk("t5_no_pop", 64'(bus.RF_RegWrite), 64'd0);
    chk("t5_data", 64'(bus.RF_WriteData), 64'hBB);

    // 6: async reset while draining
    pipe(1'b1, 5'd10, 32'h60);
    for (int i = 11; i <= 13; i++) begin
      ll(1'b1, 5'(i), 32'h200 + 32'(i));
      tick();
    end
    ll(1'b0, 5'd0, 32'd0);
    chk("t6_pend", 64'(bus.Pending), 64'h3800);
    pipe(1'b0, 5'd0, 32'd0);
    tick();
    chk("t6_drain", 64'(bus.RF_WriteRegister), 64'd11);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t6_we", 64'(bus.RF_RegWrite), 64'd0);
    chk("t6_pend0", 64'(bus.Pending), 64'd0);
    chk("t6_full", 64'(bus.Queue_Full), 64'd0);
    chk("t6_reg", 64'(bus.RF_WriteRegister), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t6_post_we", 64'(bus.RF_RegWrite), 64'd0);
      chk("t6_post_rdy", 64'(bus.LL_Ready), 64'd1);
    end
    chk("t6_post_pend", 64'(bus.Pending), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
